// File: rtl/hit_merge_fifo.sv
// hit_merge_fifo
//   Merges up to two rasterizer samples per cycle (primary and secondary
//   port) into a show-ahead FIFO of {hit, color} entries. Entry data passes
//   through unchanged.
//
// Ports
//   clk                 single clock, rising edge
//   rst                 asynchronous, active-low reset
//   hit_R18S            AXIS x SIGFIG location, primary (coordinate 0 in LSBs)
//   color_R18U          COLORS x SIGFIG color, primary (channel 0 in LSBs)
//   hit_valid_R18H      primary sample is a hit (push request)
//   hit_R18S_two, color_R18U_two, hit_valid_R18H_two   secondary port
//   hit_R19S, color_R19U  head entry (don't-care while hit_valid_R19H low)
//   hit_valid_R19H      FIFO not empty
//   hit_ready_R19H      consumer accepts the head this cycle
//   stall_RnnnnH        registered upstream throttle
//   overflow_RnnnnH     sticky: some push was dropped since reset
//   count_RnnnnU        current occupancy
//
// Handshake: the head transfers on a rising edge where hit_valid_R19H and
// hit_ready_R19H are both high; hit_ready_R19H while empty has no effect.
// The push ports have no ready: a push that does not fit is dropped and
// flagged on overflow_RnnnnH. stall_RnnnnH is advisory for upstream.
module hit_merge_fifo #(
  parameter int SIGFIG      = 24,
  parameter int AXIS        = 3,
  parameter int COLORS      = 3,
  parameter int DEPTH       = 8,
  parameter int STALL_SLACK = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIS*SIGFIG-1:0]        hit_R18S,
  input  logic [COLORS*SIGFIG-1:0]      color_R18U,
  input  logic                          hit_valid_R18H,
  input  logic [AXIS*SIGFIG-1:0]        hit_R18S_two,
  input  logic [COLORS*SIGFIG-1:0]      color_R18U_two,
  input  logic                          hit_valid_R18H_two,
  output logic [AXIS*SIGFIG-1:0]        hit_R19S,
  output logic [COLORS*SIGFIG-1:0]      color_R19U,
  output logic                          hit_valid_R19H,
  input  logic                          hit_ready_R19H,
  output logic                          stall_RnnnnH,
  output logic                          overflow_RnnnnH,
  output logic [$clog2(DEPTH):0]        count_RnnnnU
);

  localparam int HW   = AXIS * SIGFIG;
  localparam int CLW  = COLORS * SIGFIG;
  localparam int EW   = HW + CLW;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_next, free;
  logic            pop, acc_p, acc_s, drop;
  logic [PW-1:0]   sec_slot;
  logic [EW-1:0]   head;

  always_comb begin
    pop      = (count != '0) && hit_ready_R19H;
    // A same-cycle pop frees a slot that this cycle's pushes may use.
    free     = CNTW'(DEPTH) - count + CNTW'(pop);
    acc_p    = hit_valid_R18H && (free != '0);
    // The secondary needs a slot of its own behind an accepted primary.
    acc_s    = hit_valid_R18H_two &&
               (hit_valid_R18H ? (free >= CNTW'(2)) : (free != '0));
    drop     = (hit_valid_R18H && !acc_p) || (hit_valid_R18H_two && !acc_s);
    count_next = count + CNTW'(acc_p) + CNTW'(acc_s) - CNTW'(pop);
    // Secondary lands right behind the primary; pointer arithmetic wraps
    // naturally because DEPTH is a power of two.
    sec_slot = wr_ptr + PW'(acc_p);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (acc_p) mem[wr_ptr]   <= {hit_R18S, color_R18U};
    if (acc_s) mem[sec_slot] <= {hit_R18S_two, color_R18U_two};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      stall_RnnnnH    <= 1'b0;
      overflow_RnnnnH <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + PW'(acc_p) + PW'(acc_s);
      rd_ptr       <= rd_ptr + PW'(pop);
      count        <= count_next;
      stall_RnnnnH <= (CNTW'(DEPTH) - count_next) < CNTW'(STALL_SLACK);
      if (drop) overflow_RnnnnH <= 1'b1;
    end
  end

  always_comb begin
    head           = mem[rd_ptr];
    hit_R19S       = head[EW-1:CLW];
    color_R19U     = head[CLW-1:0];
    hit_valid_R19H = (count != '0);
    count_RnnnnU   = count;
  end

endmodule

// File: tb/tb_hit_merge_fifo.sv
module tb_hit_merge_fifo;

  localparam int SIGFIG = 24;
  localparam int HW     = 3 * SIGFIG;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [HW-1:0] hit_a, col_a, hit_b, col_b, hit_o, col_o;
  logic          pv, sv, rdy, valid_o, stall_o, ovf_o;
  logic [3:0]    cnt_o;

  hit_merge_fifo dut (
    .clk                (clk),
    .rst                (rst),
    .hit_R18S           (hit_a),
    .color_R18U         (col_a),
    .hit_valid_R18H     (pv),
    .hit_R18S_two       (hit_b),
    .color_R18U_two     (col_b),
    .hit_valid_R18H_two (sv),
    .hit_R19S           (hit_o),
    .color_R19U         (col_o),
    .hit_valid_R19H     (valid_o),
    .hit_ready_R19H     (rdy),
    .stall_RnnnnH       (stall_o),
    .overflow_RnnnnH    (ovf_o),
    .count_RnnnnU       (cnt_o)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample x -> hit (x, x+1, x+2), color (10x, 20x, 30x); coordinate 0 in LSBs.
  function automatic logic [HW-1:0] mk_hit(input int x);
    return {24'(x + 2), 24'(x + 1), 24'(x)};
  endfunction
  function automatic logic [HW-1:0] mk_col(input int x);
    return {24'(30 * x), 24'(20 * x), 24'(10 * x)};
  endfunction

  typedef struct {
    string name;
    bit    pv; int px;
    bit    sv; int sx;
    bit    rdy;
    bit    e_valid; int e_x; int e_cnt; bit e_stall; bit e_ovf;
  } vec_t;

  vec_t tbl[$];

  // ---------------- driver ----------------
  task automatic drive(input bit p, input int px, input bit s, input int sx, input bit r);
    @(negedge clk);
    pv = p; hit_a = mk_hit(px); col_a = mk_col(px);
    sv = s; hit_b = mk_hit(sx); col_b = mk_col(sx);
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input bit v, input int x, input int c,
                            input bit st, input bit ov);
    check({n, ".valid"}, 128'(valid_o), 128'(v));
    check({n, ".count"}, 128'(cnt_o), 128'(c));
    check({n, ".stall"}, 128'(stall_o), 128'(st));
    check({n, ".ovf"},   128'(ovf_o), 128'(ov));
    if (v) begin
      check({n, ".hit"},   128'(hit_o), 128'(mk_hit(x)));
      check({n, ".color"}, 128'(col_o), 128'(mk_col(x)));
    end
  endtask

  initial begin
    pv = 0; sv = 0; rdy = 0;
    hit_a = '0; col_a = '0; hit_b = '0; col_b = '0;

    //            name       pv px  sv sx  rdy  valid x  cnt stall ovf
    tbl.push_back('{"single",  1, 1,  0, 0,  0,   1,  1,  1,  0,  0});
    tbl.push_back('{"pop1",    0, 0,  0, 0,  1,   0,  0,  0,  0,  0});
    tbl.push_back('{"dual",    1, 2,  1, 3,  1,   1,  2,  2,  0,  0});
    tbl.push_back('{"dualB",   0, 0,  0, 0,  1,   1,  3,  1,  0,  0});
    tbl.push_back('{"dualE",   0, 0,  0, 0,  1,   0,  0,  0,  0,  0});
    tbl.push_back('{"fill2",   1, 10, 1, 11, 0,   1, 10,  2,  0,  0});
    tbl.push_back('{"fill4",   1, 12, 1, 13, 0,   1, 10,  4,  0,  0});
    tbl.push_back('{"fill6",   1, 14, 1, 15, 0,   1, 10,  6,  1,  0});
    tbl.push_back('{"fill8",   1, 16, 1, 17, 0,   1, 10,  8,  1,  0});
    tbl.push_back('{"full",    1, 18, 1, 19, 0,   1, 10,  8,  1,  1});
    tbl.push_back('{"fullpop", 1, 20, 1, 21, 1,   1, 11,  8,  1,  1});
    tbl.push_back('{"dr7",     0, 0,  0, 0,  1,   1, 12,  7,  1,  1});
    tbl.push_back('{"dr6",     0, 0,  0, 0,  1,   1, 13,  6,  1,  1});
    tbl.push_back('{"dr5",     0, 0,  0, 0,  1,   1, 14,  5,  1,  1});
    tbl.push_back('{"dr4",     0, 0,  0, 0,  1,   1, 15,  4,  0,  1});
    tbl.push_back('{"dr3",     0, 0,  0, 0,  1,   1, 16,  3,  0,  1});
    tbl.push_back('{"dr2",     0, 0,  0, 0,  1,   1, 17,  2,  0,  1});
    tbl.push_back('{"dr1",     0, 0,  0, 0,  1,   1, 20,  1,  0,  1});
    tbl.push_back('{"dr0",     0, 0,  0, 0,  1,   0,  0,  0,  0,  1});
    tbl.push_back('{"seconly", 0, 0,  1, 30, 0,   1, 30,  1,  0,  1});

    // Reset state
    #2;
    expect_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i])
      begin
        drive(tbl[i].pv, tbl[i].px, tbl[i].sv, tbl[i].sx, tbl[i].rdy);
        expect_out(tbl[i].name, tbl[i].e_valid, tbl[i].e_x, tbl[i].e_cnt,
                   tbl[i].e_stall, tbl[i].e_ovf);
      end

    // Sustained 1 push + 1 pop across pointer wrap; head follows the pushes.
    for (int i = 0; i < 20; i++) begin
      drive(1, 100 + i, 0, 0, 1);
      expect_out($sformatf("wrap%0d", i), 1, 100 + i, 1, 0, 1);
    end

    // Build occupancy 5, then assert reset between edges.
    drive(1, 200, 1, 201, 0);
    expect_out("pre3", 1, 119, 3, 0, 1);
    drive(1, 202, 1, 203, 0);
    expect_out("pre5", 1, 119, 5, 1, 1);
    @(negedge clk);
    pv = 0; sv = 0; rdy = 0;
    rst = 1'b0;
    #1;
    expect_out("midrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 50, 0, 0, 0);
    expect_out("postrst", 1, 50, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    expect_out("postpop", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
